// File: rtl/soin_mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
// Optional trapping is enabled by defining SOIN_MC_TRAP_EN.
package soin_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRC1_RS1   = 2'b00;
  localparam logic [1:0] SRC1_PC    = 2'b01;
  localparam logic [1:0] SRC1_OLDPC = 2'b10;

  localparam logic [1:0] SRC2_RS2  = 2'b00;
  localparam logic [1:0] SRC2_FOUR = 2'b01;
  localparam logic [1:0] SRC2_IMM  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_CMP   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ITYPE = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_AUIPC = 3'b101;

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode-to-instruction-class decoder.
module mc_op_class
  import soin_mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [3:0] op_class
);

  always_comb begin
    op_class = C_ILLEGAL;
    case (op)
      OP_R:      op_class = C_R;
      OP_I:      op_class = C_I;
      OP_LOAD:   op_class = C_LOAD;
      OP_STORE:  op_class = C_STORE;
      OP_BRANCH: op_class = C_BRANCH;
      OP_LUI:    op_class = C_LUI;
      OP_AUIPC:  op_class = C_AUIPC;
      OP_JAL:    op_class = C_JAL;
      OP_JALR:   op_class = C_JALR;
      default:   op_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Registered FETCH/DECODE/EXECUTE/MEM/WB control FSM for the RV32I multi-cycle datapath.
// Define SOIN_MC_TRAP_EN to trap on illegal opcodes and memory timeouts.
module multicycle_control
  import soin_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [6:0]         i_OPCode,
  input  logic               i_MemReady,
  output logic               o_PCWrite,
  output logic               o_PCWriteCond,
  output logic               o_PCSrc,
  output logic               o_IRWrite,
  output logic               o_IorD,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic [1:0]         o_WBSel,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic [1:0]         o_ALUSrc1,
  output logic [1:0]         o_ALUSrc2,
  output logic               o_RegWrite,
  output logic               o_InstRet,
  output logic [2:0]         o_State,
  output logic               o_Trap,
  output logic [1:0]         o_TrapCause
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nx;
  logic [6:0]        r_op;
  logic [3:0]        cls_op;
  logic [WCNT_W-1:0] wait_cnt;
  logic              waiting, timeout;

  logic       pc_write, pc_write_cond, pc_src, ir_write, iord;
  logic       mem_read, mem_write, reg_write, inst_ret;
  logic [1:0] wb_sel, alu_src1, alu_src2;
  logic [2:0] alu_op;

  // Execution-side decode follows the latched opcode, not the live IR field.
  mc_op_class u_cls_op (.op(r_op), .op_class(cls_op));

  assign waiting = (state == S_FETCH || state == S_MEM) && !i_MemReady;

`ifdef SOIN_MC_TRAP_EN
  logic [3:0] cls_dec;
  logic [1:0] cause_q, cause_nx;

  mc_op_class u_cls_dec (.op(i_OPCode), .op_class(cls_dec));

  // Trap on the wait cycle that would bring the count up to MEM_TIMEOUT.
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (int'(wait_cnt) >= MEM_TIMEOUT - 1);

  always_ff @(posedge i_Clk) begin
    if (i_Rst)                                       cause_q <= CAUSE_NONE;
    else if (state != S_TRAP && state_nx == S_TRAP)  cause_q <= cause_nx;
  end

  assign o_Trap      = !i_Rst && (state == S_TRAP);
  assign o_TrapCause = (!i_Rst && state == S_TRAP) ? cause_q : CAUSE_NONE;
`else
  assign timeout     = 1'b0;
  assign o_Trap      = 1'b0;
  assign o_TrapCause = CAUSE_NONE;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= S_FETCH;
      r_op     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) r_op <= i_OPCode;
      if (state_nx != state)                 wait_cnt <= '0;
      else if (waiting && wait_cnt != '1)    wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    inst_ret      = 1'b0;
    wb_sel        = WB_ALU;
    alu_src1      = SRC1_RS1;
    alu_src2      = SRC2_RS2;
    alu_op        = ALU_ADD;
`ifdef SOIN_MC_TRAP_EN
    cause_nx      = CAUSE_NONE;
`endif
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src1 = SRC1_PC;
        alu_src2 = SRC2_FOUR;
        if (i_MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end else if (timeout) begin
          state_nx = S_TRAP;
`ifdef SOIN_MC_TRAP_EN
          cause_nx = CAUSE_TIMEOUT;
`endif
        end
      end
      S_DECODE: begin
        // Speculative branch/JAL target computed into ALUOut.
        alu_src1 = SRC1_OLDPC;
        alu_src2 = SRC2_IMM;
        state_nx = S_EXECUTE;
`ifdef SOIN_MC_TRAP_EN
        if (cls_dec == C_ILLEGAL) begin
          state_nx = S_TRAP;
          cause_nx = CAUSE_ILLEGAL;
        end
`endif
      end
      S_EXECUTE: begin
        state_nx = S_WB;
        case (cls_op)
          C_R:     alu_op = ALU_RTYPE;
          C_I:     begin alu_op = ALU_ITYPE; alu_src2 = SRC2_IMM; end
          C_LOAD, C_STORE: begin
            alu_src2 = SRC2_IMM;
            state_nx = S_MEM;
          end
          C_BRANCH: begin
            alu_op        = ALU_CMP;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            inst_ret      = 1'b1;
            state_nx      = S_FETCH;
          end
          C_LUI:   begin alu_op = ALU_LUI; alu_src2 = SRC2_IMM; end
          C_AUIPC: begin
            alu_op   = ALU_AUIPC;
            alu_src1 = SRC1_OLDPC;
            alu_src2 = SRC2_IMM;
          end
          C_JAL:   begin pc_write = 1'b1; pc_src = 1'b1; end
          C_JALR:  begin alu_src2 = SRC2_IMM; pc_write = 1'b1; end
          default: begin inst_ret = 1'b1; state_nx = S_FETCH; end
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (cls_op == C_LOAD) mem_read  = 1'b1;
        else                  mem_write = 1'b1;
        if (i_MemReady) begin
          if (cls_op == C_LOAD) state_nx = S_WB;
          else begin
            inst_ret = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (timeout) begin
          state_nx = S_TRAP;
`ifdef SOIN_MC_TRAP_EN
          cause_nx = CAUSE_TIMEOUT;
`endif
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        inst_ret  = 1'b1;
        state_nx  = S_FETCH;
        if (cls_op == C_LOAD)                       wb_sel = WB_MEM;
        else if (cls_op == C_JAL || cls_op == C_JALR) wb_sel = WB_PC;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end

  // Reset forces every output low in the same cycle, including a pending memory request.
  assign o_PCWrite     = pc_write      & ~i_Rst;
  assign o_PCWriteCond = pc_write_cond & ~i_Rst;
  assign o_PCSrc       = pc_src        & ~i_Rst;
  assign o_IRWrite     = ir_write      & ~i_Rst;
  assign o_IorD        = iord          & ~i_Rst;
  assign o_MemRead     = mem_read      & ~i_Rst;
  assign o_MemWrite    = mem_write     & ~i_Rst;
  assign o_RegWrite    = reg_write     & ~i_Rst;
  assign o_InstRet     = inst_ret      & ~i_Rst;
  assign o_WBSel       = i_Rst ? 2'b00 : wb_sel;
  assign o_ALUSrc1     = i_Rst ? 2'b00 : alu_src1;
  assign o_ALUSrc2     = i_Rst ? 2'b00 : alu_src2;
  assign o_ALUOp       = i_Rst ? '0 : ALUOP_W'(alu_op);
  assign o_State       = i_Rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle expected control vectors.
module tb_multicycle_control;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_LUI = 7'b0110111;
  localparam logic [6:0] T_AUI = 7'b0010111;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_JR  = 7'b1100111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, pcwc, pcsrc, irw, iord, mr, mw;
    logic [1:0] wbsel;
    logic [2:0] aluop;
    logic [1:0] s1, s2;
    logic       rw, iret, trap;
    logic [1:0] cause;
  } obs_t;

  logic clk = 1'b0;
  logic rst, rdy;
  logic [6:0] opc;
  logic pcw, pcwc, pcsrc, irw, iord, mr, mw, rw, iret, trap;
  logic [1:0] wbsel, s1, s2, cause;
  logic [2:0] aluop, st;
  obs_t got_now;
  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(3), .ALUOP_W(3)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_OPCode(opc), .i_MemReady(rdy),
    .o_PCWrite(pcw), .o_PCWriteCond(pcwc), .o_PCSrc(pcsrc), .o_IRWrite(irw),
    .o_IorD(iord), .o_MemRead(mr), .o_MemWrite(mw), .o_WBSel(wbsel),
    .o_ALUOp(aluop), .o_ALUSrc1(s1), .o_ALUSrc2(s2), .o_RegWrite(rw),
    .o_InstRet(iret), .o_State(st), .o_Trap(trap), .o_TrapCause(cause)
  );

  assign got_now = {st, pcw, pcwc, pcsrc, irw, iord, mr, mw, wbsel, aluop, s1, s2,
                    rw, iret, trap, cause};

  function automatic obs_t e_zero();
    obs_t e = '0;
    return e;
  endfunction

  function automatic obs_t e_fetch(logic r);
    obs_t e = '0;
    e.st = 3'd0; e.mr = 1'b1; e.s1 = 2'b01; e.s2 = 2'b01;
    if (r) begin e.irw = 1'b1; e.pcw = 1'b1; end
    return e;
  endfunction

  function automatic obs_t e_dec();
    obs_t e = '0;
    e.st = 3'd1; e.s1 = 2'b10; e.s2 = 2'b10;
    return e;
  endfunction

  function automatic obs_t e_exec(logic [6:0] op);
    obs_t e = '0;
    e.st = 3'd2;
    case (op)
      T_R:        e.aluop = 3'b010;
      T_I:        begin e.aluop = 3'b011; e.s2 = 2'b10; end
      T_LD, T_ST: e.s2 = 2'b10;
      T_BR:       begin e.aluop = 3'b001; e.pcwc = 1'b1; e.pcsrc = 1'b1; e.iret = 1'b1; end
      T_LUI:      begin e.aluop = 3'b100; e.s2 = 2'b10; end
      T_AUI:      begin e.aluop = 3'b101; e.s1 = 2'b10; e.s2 = 2'b10; end
      T_JAL:      begin e.pcw = 1'b1; e.pcsrc = 1'b1; end
      T_JR:       begin e.s2 = 2'b10; e.pcw = 1'b1; end
      default:    e.iret = 1'b1;
    endcase
    return e;
  endfunction

  function automatic obs_t e_mem(logic load, logic r);
    obs_t e = '0;
    e.st = 3'd3; e.iord = 1'b1;
    if (load) e.mr = 1'b1;
    else      e.mw = 1'b1;
    if (!load && r) e.iret = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_wb(logic [1:0] sel);
    obs_t e = '0;
    e.st = 3'd4; e.rw = 1'b1; e.iret = 1'b1; e.wbsel = sel;
    return e;
  endfunction

  function automatic obs_t e_trap(logic [1:0] c);
    obs_t e = '0;
    e.st = 3'd5; e.trap = 1'b1; e.cause = c;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, check them on the falling edge.
  task automatic step(input string tag, input logic [6:0] op, input logic r, input logic rs,
                      input obs_t e);
    obs_t want;
    opc = op; rdy = r; rst = rs;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    vectors++;
    assert (got_now === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got_now, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    step("rst0", T_R, 1'b0, 1'b1, e_zero());
    step("rst1", T_R, 1'b1, 1'b1, e_zero());

    // R-type; live opcode changed after DECODE must not matter
    step("r_fetch", T_R,  1'b1, 1'b0, e_fetch(1'b1));
    step("r_dec",   T_R,  1'b1, 1'b0, e_dec());
    step("r_exec",  T_BR, 1'b1, 1'b0, e_exec(T_R));
    step("r_wb",    T_BR, 1'b1, 1'b0, e_wb(2'b00));

    // load, two MEM wait states
    step("ld_fetch", T_LD, 1'b1, 1'b0, e_fetch(1'b1));
    step("ld_dec",   T_LD, 1'b1, 1'b0, e_dec());
    step("ld_exec",  T_LD, 1'b1, 1'b0, e_exec(T_LD));
    step("ld_mem0",  T_LD, 1'b0, 1'b0, e_mem(1'b1, 1'b0));
    step("ld_mem1",  T_LD, 1'b0, 1'b0, e_mem(1'b1, 1'b0));
    step("ld_mem2",  T_LD, 1'b1, 1'b0, e_mem(1'b1, 1'b1));
    step("ld_wb",    T_LD, 1'b0, 1'b0, e_wb(2'b01));

    step("br_fetch", T_BR, 1'b1, 1'b0, e_fetch(1'b1));
    step("br_dec",   T_BR, 1'b1, 1'b0, e_dec());
    step("br_exec",  T_BR, 1'b1, 1'b0, e_exec(T_BR));

    step("jr_fetch", T_JR, 1'b1, 1'b0, e_fetch(1'b1));
    step("jr_dec",   T_JR, 1'b1, 1'b0, e_dec());
    step("jr_exec",  T_JR, 1'b1, 1'b0, e_exec(T_JR));
    step("jr_wb",    T_JR, 1'b1, 1'b0, e_wb(2'b10));

    step("jal_fetch", T_JAL, 1'b1, 1'b0, e_fetch(1'b1));
    step("jal_dec",   T_JAL, 1'b1, 1'b0, e_dec());
    step("jal_exec",  T_JAL, 1'b1, 1'b0, e_exec(T_JAL));
    step("jal_wb",    T_JAL, 1'b1, 1'b0, e_wb(2'b10));

    // store, one fetch wait and one MEM wait
    step("st_fetch0", T_ST, 1'b0, 1'b0, e_fetch(1'b0));
    step("st_fetch1", T_ST, 1'b1, 1'b0, e_fetch(1'b1));
    step("st_dec",    T_ST, 1'b1, 1'b0, e_dec());
    step("st_exec",   T_ST, 1'b1, 1'b0, e_exec(T_ST));
    step("st_mem0",   T_ST, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
    step("st_mem1",   T_ST, 1'b1, 1'b0, e_mem(1'b0, 1'b1));

    step("i_fetch", T_I, 1'b1, 1'b0, e_fetch(1'b1));
    step("i_dec",   T_I, 1'b1, 1'b0, e_dec());
    step("i_exec",  T_I, 1'b1, 1'b0, e_exec(T_I));
    step("i_wb",    T_I, 1'b1, 1'b0, e_wb(2'b00));

    step("lui_fetch", T_LUI, 1'b1, 1'b0, e_fetch(1'b1));
    step("lui_dec",   T_LUI, 1'b1, 1'b0, e_dec());
    step("lui_exec",  T_LUI, 1'b1, 1'b0, e_exec(T_LUI));
    step("lui_wb",    T_LUI, 1'b1, 1'b0, e_wb(2'b00));

    step("aui_fetch", T_AUI, 1'b1, 1'b0, e_fetch(1'b1));
    step("aui_dec",   T_AUI, 1'b1, 1'b0, e_dec());
    step("aui_exec",  T_AUI, 1'b1, 1'b0, e_exec(T_AUI));
    step("aui_wb",    T_AUI, 1'b1, 1'b0, e_wb(2'b00));

    // unknown opcode
    step("bad_fetch", T_BAD, 1'b1, 1'b0, e_fetch(1'b1));
    step("bad_dec",   T_BAD, 1'b1, 1'b0, e_dec());
`ifdef SOIN_MC_TRAP_EN
    for (int i = 0; i < 20; i++) step("bad_trap", T_BAD, 1'b1, 1'b0, e_trap(2'b01));
    step("bad_rst", T_BAD, 1'b0, 1'b1, e_zero());
`else
    step("bad_exec",  T_BAD, 1'b1, 1'b0, e_exec(T_BAD));
`endif

    // reset lands on the store's ready cycle: no InstRet, request dropped
    step("sr_fetch", T_ST, 1'b1, 1'b0, e_fetch(1'b1));
    step("sr_dec",   T_ST, 1'b1, 1'b0, e_dec());
    step("sr_exec",  T_ST, 1'b1, 1'b0, e_exec(T_ST));
    step("sr_mem",   T_ST, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
    step("sr_rst",   T_ST, 1'b1, 1'b1, e_zero());
    step("sr_after", T_ST, 1'b0, 1'b0, e_fetch(1'b0));
    step("to_rst",   T_R,  1'b0, 1'b1, e_zero());

    // fetch with ready held low
`ifdef SOIN_MC_TRAP_EN
    for (int i = 0; i < 3; i++) step("to_wait", T_R, 1'b0, 1'b0, e_fetch(1'b0));
    for (int i = 0; i < 3; i++) step("to_trap", T_R, 1'b1, 1'b0, e_trap(2'b10));
`else
    for (int i = 0; i < 5; i++) step("to_wait", T_R, 1'b0, 1'b0, e_fetch(1'b0));
    step("to_ready", T_R, 1'b1, 1'b0, e_fetch(1'b1));
    step("to_dec",   T_R, 1'b1, 1'b0, e_dec());
`endif
    step("end_rst", T_R, 1'b0, 1'b1, e_zero());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
